kick_anim_ctrl: RTL and testbench
=================================

// Module: kick_anim_ctrl
// PURPOSE
//  Upstream of the kick sprite renderer. Sequences the kick animation (idle/windup/strike/recover/cooldown),
//  advancing only on frame boundaries. Converts beam position (DrawX/DrawY) and player position into a
//  sprite-local ROM address with optional horizontal mirroring, plus an in-box flag for the colour mux.
//  Also reports busy and strike-active status to game logic.
// PARAMETERS
//  SPRITE_W        64  sprite width in pixels, power of 2
//  SPRITE_H        64  sprite height in pixels, power of 2
//  WINDUP_FRAMES    4  frames spent in WINDUP, range 1..255
//  STRIKE_FRAMES    6  frames spent in STRIKE, range 1..255
//  RECOVER_FRAMES   4  frames spent in RECOVER, range 1..255
//  COOLDOWN_FRAMES  8  frames spent in COOLDOWN, range 1..255
// PORTS
//  vga_clk       in   1   pixel clock; the only clock
//  reset         in   1   synchronous, active-high reset
//  frame_tick    in   1   one-cycle pulse, once per frame at vblank start
//  kick_req      in   1   one-cycle kick request from input logic
//  facing_left   in   1   1 = mirror sprite horizontally
//  player_x      in   10  sprite top-left X, screen pixels
//  player_y      in   10  sprite top-left Y, screen pixels
//  DrawX         in   10  current beam X
//  DrawY         in   10  current beam Y
//  rom_address   out  14  {frame_idx[1:0], local_y[5:0], local_x[5:0]}
//  sprite_on     out  1   beam inside the sprite box
//  frame_idx     out  2   sprite frame currently shown
//  busy          out  1   animation in progress (state != IDLE)
//  strike_active out  1   high while in STRIKE, for hit detection
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, phase counter=0, latched facing=0, latched pos=0; all outputs 0.
//  FSM: IDLE -> WINDUP -> STRIKE -> RECOVER -> COOLDOWN -> IDLE. State changes only in a frame_tick cycle.
//  pending: set by kick_req while in IDLE; cleared on leaving IDLE. kick_req in any other state is dropped.
//  IDLE: on frame_tick with (pending | kick_req), go to WINDUP and load cnt=WINDUP_FRAMES.
//  Other states: on each frame_tick, if cnt==1 go to the next state and load that state's *_FRAMES;
//   otherwise cnt<=cnt-1. Each phase therefore lasts exactly N frames.
//  frame_idx: IDLE=0, WINDUP=1, STRIKE=2, RECOVER=1, COOLDOWN=0. It is registered and updates in the
//   same edge as the state.
//  busy = (state!=IDLE). strike_active = (state==STRIKE). Both are registered with the state.
//  facing_left, player_x and player_y are sampled on every frame_tick, so they stay stable across a frame.
//  Address path: dx = {1'b0,DrawX} - {1'b0,px}, dy likewise; both 11-bit.
//   in_box = dx[10]==0 && dx<SPRITE_W && dy[10]==0 && dy<SPRITE_H.
//   lx = facing ? (SPRITE_W-1-dx) : dx; ly = dy.
//   rom_address <= {frame_idx, ly[5:0], lx[5:0]}; sprite_on <= in_box.
//   Latency is 1 cycle from DrawX/DrawY to the outputs.
//   When in_box=0, rom_address is 0.
//  Boundaries:
//   player_x > 576 clips at the right edge: DrawX never reaches dx>=64 beyond 639, so no wrap.
//   Reset mid-animation returns to IDLE the next edge and discards pending.
//   kick_req and frame_tick in the same IDLE cycle start WINDUP immediately.
// TESTING
//  1. Reset, then drive 10 frame_ticks with no kick -> state IDLE, frame_idx=0, busy=0 throughout.
//  2. kick_req mid-frame, then frame_tick -> busy=1 and frame_idx=1 for 4 frames; 2 for 6 frames
//     with strike_active=1; 1 for 4 frames; 0 with busy=1 for 8 frames; then busy=0.
//  3. kick_req during STRIKE and during COOLDOWN -> ignored; after return to IDLE, one further
//     frame_tick keeps IDLE.
//  4. px=100, py=200, facing=0, frame_idx=2: DrawX=100,DrawY=200 -> addr 0x2000, on=1;
//     DrawX=163,DrawY=263 -> addr 0x2FFF; DrawX=164 -> on=0, addr 0; DrawX=99 -> on=0.
//  5. Same as 4 with facing=1: DrawX=100,DrawY=200 -> lx=63, addr 0x203F. Toggle facing mid-frame ->
//     no change until the next frame_tick.
//  6. Assert reset in the 3rd STRIKE frame -> next cycle IDLE, all outputs 0. kick_req+frame_tick in the
//     same cycle -> WINDUP.

Source files
------------

// File: rtl/kick_anim_ctrl.sv
// Kick animation sequencer plus sprite-local ROM address generator.
// The phase FSM only advances on frame_tick; the address path has one cycle of latency.
module kick_anim_ctrl #(
    parameter int SPRITE_W        = 64,
    parameter int SPRITE_H        = 64,
    parameter int WINDUP_FRAMES   = 4,
    parameter int STRIKE_FRAMES   = 6,
    parameter int RECOVER_FRAMES  = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        kick_req,
    input  logic        facing_left,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [13:0] rom_address,
    output logic        sprite_on,
    output logic [1:0]  frame_idx,
    output logic        busy,
    output logic        strike_active
);

    // state    | meaning
    // IDLE     | waiting for a kick request
    // WINDUP   | leg drawn back, frame 1
    // STRIKE   | leg extended, frame 2, hit detection live
    // RECOVER  | leg returning, frame 1
    // COOLDOWN | neutral pose, still busy, frame 0
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WINDUP   = 3'd1;
    localparam logic [2:0] S_STRIKE   = 3'd2;
    localparam logic [2:0] S_RECOVER  = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;

    localparam int XW = $clog2(SPRITE_W);
    localparam int YW = $clog2(SPRITE_H);
    localparam logic [10:0] W_LIM = 11'(SPRITE_W);
    localparam logic [10:0] H_LIM = 11'(SPRITE_H);

    logic [2:0]  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        pending, pending_nxt;
    logic        facing_q;
    logic [9:0]  px_q, py_q;

    logic [10:0]   dx, dy;
    logic          in_box;
    logic [XW-1:0] lx;

    function automatic logic [1:0] idx_of(input logic [2:0] s);
        case (s)
            S_WINDUP:  idx_of = 2'd1;
            S_STRIKE:  idx_of = 2'd2;
            S_RECOVER: idx_of = 2'd1;
            default:   idx_of = 2'd0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (frame_tick) begin
            case (state)
                S_IDLE: begin
                    if (pending || kick_req) begin
                        state_nxt = S_WINDUP;
                        cnt_nxt   = 8'(WINDUP_FRAMES);
                    end
                end
                S_WINDUP: begin
                    if (cnt == 8'd1) begin
                        state_nxt = S_STRIKE;
                        cnt_nxt   = 8'(STRIKE_FRAMES);
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_STRIKE: begin
                    if (cnt == 8'd1) begin
                        state_nxt = S_RECOVER;
                        cnt_nxt   = 8'(RECOVER_FRAMES);
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (cnt == 8'd1) begin
                        state_nxt = S_COOLDOWN;
                        cnt_nxt   = 8'(COOLDOWN_FRAMES);
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_COOLDOWN: begin
                    if (cnt == 8'd1) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Requests are only remembered while idle; leaving IDLE consumes them.
    always_comb begin
        pending_nxt = pending;
        if (state == S_IDLE) begin
            if (state_nxt != S_IDLE) begin
                pending_nxt = 1'b0;
            end else if (kick_req) begin
                pending_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, px_q};
        dy     = {1'b0, DrawY} - {1'b0, py_q};
        in_box = !dx[10] && (dx < W_LIM) && !dy[10] && (dy < H_LIM);
        // For a power-of-2 width, SPRITE_W-1-dx is the bitwise complement of dx.
        lx     = facing_q ? ~dx[XW-1:0] : dx[XW-1:0];
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            pending       <= 1'b0;
            facing_q      <= 1'b0;
            px_q          <= 10'd0;
            py_q          <= 10'd0;
            frame_idx     <= 2'd0;
            busy          <= 1'b0;
            strike_active <= 1'b0;
            rom_address   <= 14'd0;
            sprite_on     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pending       <= pending_nxt;
            frame_idx     <= idx_of(state_nxt);
            busy          <= (state_nxt != S_IDLE);
            strike_active <= (state_nxt == S_STRIKE);
            if (frame_tick) begin
                facing_q <= facing_left;
                px_q     <= player_x;
                py_q     <= player_y;
            end
            sprite_on   <= in_box;
            rom_address <= in_box ? {frame_idx, dy[YW-1:0], lx} : 14'd0;
        end
    end

endmodule

// File: tb/tb_kick_anim_ctrl.sv
// Directed and randomized checks of kick_anim_ctrl against a frame-count reference model.
module tb_kick_anim_ctrl;

    localparam int WF = 4;
    localparam int SF = 6;
    localparam int RF = 4;
    localparam int CF = 8;
    localparam int TOTAL = WF + SF + RF + CF;

    logic        vga_clk = 1'b0;
    logic        reset, frame_tick, kick_req, facing_left;
    logic [9:0]  player_x, player_y, DrawX, DrawY;
    logic [13:0] rom_address;
    logic        sprite_on;
    logic [1:0]  frame_idx;
    logic        busy, strike_active;

    int checks = 0;
    int failures = 0;

    // Reference model: an animation is "active" for TOTAL frames, m_k counts frames since start.
    bit m_active, m_pend, m_face;
    int m_k, m_px, m_py;

    always #5 vga_clk = ~vga_clk;

    kick_anim_ctrl dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .kick_req      (kick_req),
        .facing_left   (facing_left),
        .player_x      (player_x),
        .player_y      (player_y),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .rom_address   (rom_address),
        .sprite_on     (sprite_on),
        .frame_idx     (frame_idx),
        .busy          (busy),
        .strike_active (strike_active)
    );

    function automatic int m_idx();
        if (!m_active)               return 0;
        if (m_k < WF)                return 1;
        if (m_k < WF + SF)           return 2;
        if (m_k < WF + SF + RF)      return 1;
        return 0;
    endfunction

    function automatic int m_strike();
        return (m_active && m_k >= WF && m_k < WF + SF) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit tick, input bit kick, input bit face,
                         input logic [9:0] px, input logic [9:0] py,
                         input logic [9:0] x, input logic [9:0] y);
        int dx, dy, e_addr;
        bit e_on;
        reset = rst; frame_tick = tick; kick_req = kick; facing_left = face;
        player_x = px; player_y = py; DrawX = x; DrawY = y;
        dx = int'(x) - m_px;
        dy = int'(y) - m_py;
        e_on = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
        e_addr = e_on ? (m_idx() * 4096 + dy * 64 + (m_face ? 63 - dx : dx)) : 0;
        if (rst) begin
            m_active = 0; m_pend = 0; m_face = 0; m_k = 0; m_px = 0; m_py = 0;
            e_on = 0; e_addr = 0;
        end else begin
            if (tick) begin
                if (m_active) begin
                    m_k++;
                    if (m_k == TOTAL) begin
                        m_active = 0;
                        m_k = 0;
                    end
                end else if (m_pend || kick) begin
                    m_active = 1;
                    m_k = 0;
                    m_pend = 0;
                end
                m_face = face; m_px = int'(px); m_py = int'(py);
            end else if (!m_active && kick) begin
                m_pend = 1;
            end
        end
        @(posedge vga_clk);
        #1;
        chk("frame_idx", 32'(frame_idx), 32'(m_idx()));
        chk("busy", 32'(busy), 32'(m_active));
        chk("strike_active", 32'(strike_active), 32'(m_strike()));
        chk("sprite_on", 32'(sprite_on), 32'(e_on));
        chk("rom_address", 32'(rom_address), 32'(e_addr));
    endtask

    initial begin
        logic [9:0] rx, ry, rpx, rpy;
        int exp_idx;
        bit rf;
        reset = 1; frame_tick = 0; kick_req = 0; facing_left = 0;
        player_x = 0; player_y = 0; DrawX = 0; DrawY = 0;
        m_active = 0; m_pend = 0; m_face = 0; m_k = 0; m_px = 0; m_py = 0;

        // Reset state
        cycle(1, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
        cycle(1, 0, 0, 0, 10'd0, 10'd0, 10'd5, 10'd5);
        chk("rst_rom", 32'(rom_address), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Ten idle frames
        for (int f = 0; f < 10; f++) begin
            cycle(0, 1, 0, 0, 10'd300, 10'd100, 10'(f * 30), 10'd110);
            chk("t1_busy", 32'(busy), 32'd0);
            cycle(0, 0, 0, 0, 10'd300, 10'd100, 10'd310, 10'd120);
        end

        // Full animation, with dropped kicks during STRIKE and COOLDOWN
        cycle(0, 0, 1, 0, 10'd100, 10'd200, 10'd0, 10'd0);
        for (int f = 0; f <= TOTAL; f++) begin
            cycle(0, 1, 0, 0, 10'd100, 10'd200, 10'(90 + f * 3), 10'(195 + f * 3));
            exp_idx = (f < 4) ? 1 : (f < 10) ? 2 : (f < 14) ? 1 : 0;
            chk("t2_idx", 32'(frame_idx), 32'(exp_idx));
            chk("t2_busy", 32'(busy), 32'(f < TOTAL));
            cycle(0, 0, (f == 6) || (f == 18), 0, 10'd100, 10'd200, 10'd120, 10'd220);
        end
        cycle(0, 1, 0, 0, 10'd100, 10'd200, 10'd0, 10'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Address path at px=100, py=200 in STRIKE
        cycle(0, 0, 1, 0, 10'd100, 10'd200, 10'd0, 10'd0);
        cycle(0, 1, 0, 0, 10'd100, 10'd200, 10'd0, 10'd0);
        for (int f = 0; f < 4; f++) cycle(0, 1, 0, 0, 10'd100, 10'd200, 10'd0, 10'd0);
        chk("t4_idx", 32'(frame_idx), 32'd2);
        cycle(0, 0, 0, 0, 10'd100, 10'd200, 10'd100, 10'd200);
        chk("t4_addr0", 32'(rom_address), 32'h2000);
        chk("t4_on0", 32'(sprite_on), 32'd1);
        cycle(0, 0, 0, 0, 10'd100, 10'd200, 10'd163, 10'd263);
        chk("t4_addr_max", 32'(rom_address), 32'h2FFF);
        cycle(0, 0, 0, 0, 10'd100, 10'd200, 10'd164, 10'd263);
        chk("t4_right_off", 32'(sprite_on), 32'd0);
        chk("t4_right_addr", 32'(rom_address), 32'd0);
        cycle(0, 0, 0, 0, 10'd100, 10'd200, 10'd99, 10'd200);
        chk("t4_left_off", 32'(sprite_on), 32'd0);

        // Mirroring, latched only on frame_tick
        cycle(0, 1, 0, 1, 10'd100, 10'd200, 10'd0, 10'd0);
        cycle(0, 0, 0, 1, 10'd100, 10'd200, 10'd100, 10'd200);
        chk("t5_mirror", 32'(rom_address), 32'h203F);
        cycle(0, 0, 0, 0, 10'd100, 10'd200, 10'd100, 10'd200);
        chk("t5_hold", 32'(rom_address), 32'h203F);

        // Reset in the third STRIKE frame, then same-cycle kick and tick
        cycle(0, 1, 0, 1, 10'd100, 10'd200, 10'd0, 10'd0);
        chk("t6_strike", 32'(strike_active), 32'd1);
        cycle(1, 0, 0, 0, 10'd100, 10'd200, 10'd100, 10'd200);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_idx", 32'(frame_idx), 32'd0);
        chk("t6_rst_strike", 32'(strike_active), 32'd0);
        cycle(0, 1, 1, 0, 10'd100, 10'd200, 10'd0, 10'd0);
        chk("t6_windup", 32'(frame_idx), 32'd1);

        // Randomized traffic
        rpx = 10'd200; rpy = 10'd150; rf = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rpx = 10'($urandom_range(0, 639));
                rpy = 10'($urandom_range(0, 479));
                rf  = 1'($urandom_range(0, 1));
            end
            rx = rpx + 10'($urandom_range(0, 72)) - 10'd4;
            ry = rpy + 10'($urandom_range(0, 72)) - 10'd4;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0, rf, rpx, rpy, rx, ry);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
